// File: rtl/mult.sv
// Iterative shift-and-add unsigned fixed-point multiplier, one multiplier bit per clock.
// Optional round-half-up of the discarded fraction bits when MULT_ROUND_EN is defined.
module mult #(
    parameter int wholeWidth    = 1,
    parameter int fractionWidth = 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                calculate_en,
    input  logic [wholeWidth+fractionWidth-1:0] valueOne,
    input  logic [wholeWidth+fractionWidth-1:0] valueTwo,
    output logic [wholeWidth+fractionWidth-1:0] product,
    output logic                                overflow,
    output logic                                busy,
    output logic                                done
);
    localparam int N  = wholeWidth + fractionWidth;
    localparam int F  = fractionWidth;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_one;
    logic [N-1:0]    r_two;
    logic [2*N-1:0]  r_acc;
    logic [CW-1:0]   r_count;

    logic [2*N-1:0]  w_addend;
    logic [N-1:0]    w_prod;
    logic            w_ovf;

    assign w_addend = {{N{1'b0}}, r_one} << r_count;

`ifdef MULT_ROUND_EN
    logic [N:0] w_rounded;
    always_comb begin
        w_rounded = {1'b0, r_acc[F +: N]} + {{N{1'b0}}, r_acc[F-1]};
        w_prod    = w_rounded[N-1:0];
        w_ovf     = (|r_acc[2*N-1:F+N]) | w_rounded[N];
    end
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^r_acc[F-1:0];
    always_comb begin
        w_prod = r_acc[F +: N];
        w_ovf  = |r_acc[2*N-1:F+N];
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_one    <= '0;
            r_two    <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            product  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (calculate_en) begin
                        r_one   <= valueOne;
                        r_two   <= valueTwo;
                        r_acc   <= '0;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (r_two[r_count]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(N - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    product  <= w_prod;
                    overflow <= w_ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
